// File: rtl/peak_scan_ctrl.sv
// Multi-channel peak scanner: settles, measures and reports the signed peak of each channel in turn.
// Define PEAK_SCAN_ABS_EN to track saturated sample magnitude instead of the raw signed value.
module peak_scan_ctrl #(
  parameter int DWIDTH = 16,
  parameter int NCH    = 4,
  parameter int WINDOW = 6000,
  parameter int SETTLE = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic                      cont,
  input  logic                      abort,
  input  logic [NCH*DWIDTH-1:0]     in_bus,
  output logic [$clog2(NCH)-1:0]    ch_sel,
  output logic                      busy,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic signed [DWIDTH-1:0]  res_peak,
  output logic [$clog2(NCH)-1:0]    res_ch
);

  localparam int CW  = $clog2(NCH);
  localparam int SCW = $clog2(SETTLE + 1);
  localparam int WCW = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_SETTLE  = 2'd1,
    S_MEASURE = 2'd2,
    S_REPORT  = 2'd3
  } state_t;

  state_t                    r_state;
  logic [CW-1:0]             r_ch_sel;
  logic [SCW-1:0]            r_set_cnt;
  logic [WCW-1:0]            r_win_cnt;
  logic signed [DWIDTH-1:0]  r_peak;
  logic signed [DWIDTH-1:0]  r_res_peak;
  logic [CW-1:0]             r_res_ch;
  logic                      r_res_valid;
  logic                      r_busy;

  logic signed [DWIDTH-1:0]  w_raw;
  logic signed [DWIDTH-1:0]  w_cmp;
  logic signed [DWIDTH-1:0]  w_peak_next;
  logic                      w_last_ch;

`ifdef PEAK_SCAN_ABS_EN
  // The most negative code has no positive twin, so it clamps to the largest positive value.
  function automatic logic signed [DWIDTH-1:0] f_abs_sat(input logic signed [DWIDTH-1:0] v);
    logic signed [DWIDTH-1:0] r;
    if (v == {1'b1, {(DWIDTH-1){1'b0}}}) begin
      r = {1'b0, {(DWIDTH-1){1'b1}}};
    end else if (v[DWIDTH-1]) begin
      r = -v;
    end else begin
      r = v;
    end
    return r;
  endfunction
`endif

  assign w_raw     = in_bus[r_ch_sel*DWIDTH +: DWIDTH];
  assign w_last_ch = (r_ch_sel == CW'(NCH - 1));

  // Running-peak update: the first window sample loads unconditionally.
  always_comb begin
`ifdef PEAK_SCAN_ABS_EN
    w_cmp = f_abs_sat(w_raw);
`else
    w_cmp = w_raw;
`endif
    w_peak_next = r_peak;
    if (r_win_cnt == {WCW{1'b0}}) begin
      w_peak_next = w_cmp;
    end else if (w_cmp > r_peak) begin
      w_peak_next = w_cmp;
    end else begin
      w_peak_next = r_peak;
    end
  end

  // Scan sequencer with all outputs registered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_ch_sel    <= {CW{1'b0}};
      r_set_cnt   <= {SCW{1'b0}};
      r_win_cnt   <= {WCW{1'b0}};
      r_peak      <= {DWIDTH{1'b0}};
      r_res_peak  <= {DWIDTH{1'b0}};
      r_res_ch    <= {CW{1'b0}};
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (abort) begin
      r_state     <= S_IDLE;
      r_set_cnt   <= {SCW{1'b0}};
      r_win_cnt   <= {WCW{1'b0}};
      r_peak      <= {DWIDTH{1'b0}};
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_ch_sel  <= {CW{1'b0}};
            r_set_cnt <= {SCW{1'b0}};
            r_state   <= S_SETTLE;
            r_busy    <= 1'b1;
          end
        end
        S_SETTLE: begin
          if (r_set_cnt == SCW'(SETTLE - 1)) begin
            r_set_cnt <= {SCW{1'b0}};
            r_win_cnt <= {WCW{1'b0}};
            r_state   <= S_MEASURE;
          end else begin
            r_set_cnt <= r_set_cnt + 1'b1;
          end
        end
        S_MEASURE: begin
          r_peak <= w_peak_next;
          // The result register takes the combinational peak so the final sample is included.
          if (r_win_cnt == WCW'(WINDOW - 1)) begin
            r_win_cnt   <= {WCW{1'b0}};
            r_res_peak  <= w_peak_next;
            r_res_ch    <= r_ch_sel;
            r_res_valid <= 1'b1;
            r_state     <= S_REPORT;
          end else begin
            r_win_cnt <= r_win_cnt + 1'b1;
          end
        end
        S_REPORT: begin
          if (r_res_valid && res_ready) begin
            r_res_valid <= 1'b0;
            r_set_cnt   <= {SCW{1'b0}};
            if (!w_last_ch) begin
              r_ch_sel <= r_ch_sel + 1'b1;
              r_state  <= S_SETTLE;
            end else if (cont) begin
              r_ch_sel <= {CW{1'b0}};
              r_state  <= S_SETTLE;
            end else begin
              r_state <= S_IDLE;
              r_busy  <= 1'b0;
            end
          end
        end
        default: begin
          r_state     <= S_IDLE;
          r_res_valid <= 1'b0;
          r_busy      <= 1'b0;
        end
      endcase
    end
  end

  assign ch_sel    = r_ch_sel;
  assign busy      = r_busy;
  assign res_valid = r_res_valid;
  assign res_peak  = r_res_peak;
  assign res_ch    = r_res_ch;

endmodule

// File: tb/tb_peak_scan_ctrl.sv
// Directed self-checking bench for peak_scan_ctrl (NCH=4, WINDOW=8, SETTLE=2).
module tb_peak_scan_ctrl;

  localparam int DW  = 16;
  localparam int NCH = 4;
  localparam int WIN = 8;
  localparam int SET = 2;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 start;
  logic                 cont;
  logic                 abort;
  logic [NCH*DW-1:0]    in_bus;
  logic [1:0]           ch_sel;
  logic                 busy;
  logic                 res_valid;
  logic                 res_ready;
  logic signed [DW-1:0] res_peak;
  logic [1:0]           res_ch;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t0      = 0;
  int last    = 0;
  int n_seen  = 0;

  peak_scan_ctrl #(.DWIDTH(DW), .NCH(NCH), .WINDOW(WIN), .SETTLE(SET)) dut (
    .clk(clk), .rst(rst), .start(start), .cont(cont), .abort(abort),
    .in_bus(in_bus), .ch_sel(ch_sel), .busy(busy), .res_valid(res_valid),
    .res_ready(res_ready), .res_peak(res_peak), .res_ch(res_ch)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic signed [31:0] obs,
                           input logic signed [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic set_ch(input int k, input int v);
    in_bus[k*DW +: DW] = v[DW-1:0];
  endtask

  task automatic wait_valid();
    int n;
    n = 0;
    while (!res_valid && n < 60) begin
      tick();
      n++;
    end
  endtask

  function automatic int ref_peak(input int v);
`ifdef PEAK_SCAN_ABS_EN
    if (v < -32767) return 32767;
    return (v < 0) ? -v : v;
`else
    return v;
`endif
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; cont = 1'b0; abort = 1'b0; res_ready = 1'b0; in_bus = '0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ch_sel", 32'(ch_sel), 0);
    check_val("rst_busy", 32'(busy), 0);
    check_val("rst_valid", 32'(res_valid), 0);
    check_val("rst_peak", 32'(res_peak), 0);
    check_val("rst_res_ch", 32'(res_ch), 0);
    rst = 1'b0;
    tick();

    // Four constant channels, single scan, no backpressure
    for (int k = 0; k < NCH; k++) set_ch(k, 10*k - 15);
    res_ready = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    t0 = cyc;
    check_val("a_busy", 32'(busy), 1);
    for (int r = 0; r < NCH; r++) begin
      wait_valid();
      check_val("a_valid", 32'(res_valid), 1);
      check_val("a_peak", 32'(res_peak), ref_peak(10*r - 15));
      check_val("a_ch", 32'(res_ch), r);
      if (r == 0) check_val("a_latency", cyc - t0, SET + WIN);
      else        check_val("a_spacing", cyc - last, SET + WIN + 1);
      last = cyc;
      tick();
    end
    check_val("a_busy_end", 32'(busy), 0);
    check_val("a_valid_end", 32'(res_valid), 0);
    repeat (5) tick();
    check_val("a_idle_peak", 32'(res_peak), ref_peak(15));
    check_val("a_idle_ch", 32'(res_ch), 3);

    // Ramp on channel 1 whose final sample is the peak; settle-period values must be ignored
    set_ch(0, -7);
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 1; n <= 21; n++) begin
      if (n >= 14) set_ch(1, (n == 21) ? 100 : n - 14);
      else         set_ch(1, 30000);
      tick();
      if (n == 10) begin
        check_val("b_ch0_valid", 32'(res_valid), 1);
        check_val("b_ch0_peak", 32'(res_peak), ref_peak(-7));
      end
    end
    check_val("b_valid", 32'(res_valid), 1);
    check_val("b_ch", 32'(res_ch), 1);
    check_val("b_peak", 32'(res_peak), 100);
    abort = 1'b1; tick(); abort = 1'b0;
    check_val("b_abort_valid", 32'(res_valid), 0);
    check_val("b_abort_busy", 32'(busy), 0);

    // Backpressure: result held for 50 cycles while inputs keep moving
    res_ready = 1'b0;
    set_ch(0, 42);
    start = 1'b1; tick(); start = 1'b0;
    wait_valid();
    for (int i = 0; i < 50; i++) begin
      set_ch(0, 1000 + i);
      tick();
      check_val("c_valid", 32'(res_valid), 1);
      check_val("c_peak", 32'(res_peak), 42);
      check_val("c_ch", 32'(res_ch), 0);
      check_val("c_ch_sel", 32'(ch_sel), 0);
    end
    res_ready = 1'b1;
    tick();
    check_val("c_release_valid", 32'(res_valid), 0);
    check_val("c_release_ch_sel", 32'(ch_sel), 1);
    abort = 1'b1; tick(); abort = 1'b0;

    // Continuous mode over two scans, then stop at the next wrap
    for (int k = 0; k < NCH; k++) set_ch(k, 10*k - 15);
    cont = 1'b1;
    start = 1'b1; tick(); start = 1'b0;
    for (int r = 0; r < 2*NCH; r++) begin
      wait_valid();
      check_val("d_ch_sel", 32'(ch_sel), r % NCH);
      check_val("d_res_ch", 32'(res_ch), r % NCH);
      if (r == 2*NCH - 1) cont = 1'b0;
      tick();
      if (r == NCH - 1) begin
        check_val("d_wrap_ch_sel", 32'(ch_sel), 0);
        check_val("d_wrap_busy", 32'(busy), 1);
      end
    end
    check_val("d_stop_busy", 32'(busy), 0);

    // Abort in the middle of channel 2's window
    start = 1'b1; tick(); start = 1'b0;
    repeat (27) tick();
    check_val("e_pre_ch_sel", 32'(ch_sel), 2);
    check_val("e_pre_busy", 32'(busy), 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check_val("e_busy", 32'(busy), 0);
    check_val("e_valid", 32'(res_valid), 0);
    n_seen = 0;
    repeat (30) begin tick(); if (res_valid) n_seen++; end
    check_val("e_no_result", n_seen, 0);

    // Abort coincident with the handshake
    start = 1'b1; tick(); start = 1'b0;
    wait_valid();
    check_val("f_valid_before", 32'(res_valid), 1);
    abort = 1'b1; tick(); abort = 1'b0;
    check_val("f_busy", 32'(busy), 0);
    check_val("f_valid", 32'(res_valid), 0);
    n_seen = 0;
    repeat (20) begin tick(); if (res_valid || busy) n_seen++; end
    check_val("f_quiet", n_seen, 0);

    // Abort wins over start in IDLE
    start = 1'b1; abort = 1'b1; tick(); start = 1'b0; abort = 1'b0;
    check_val("g_busy", 32'(busy), 0);

    // Asynchronous reset mid-window on channel 1
    start = 1'b1; tick(); start = 1'b0;
    repeat (16) tick();
    check_val("h_pre_ch_sel", 32'(ch_sel), 1);
    rst = 1'b1;
    #2;
    check_val("h_ch_sel", 32'(ch_sel), 0);
    check_val("h_busy", 32'(busy), 0);
    check_val("h_valid", 32'(res_valid), 0);
    check_val("h_peak", 32'(res_peak), 0);
    check_val("h_res_ch", 32'(res_ch), 0);
    tick();
    rst = 1'b0;
    n_seen = 0;
    repeat (20) begin tick(); if (busy || res_valid || res_peak != 0 || ch_sel != 0) n_seen++; end
    check_val("h_quiet", n_seen, 0);

    // Most negative sample followed by a small positive value
    start = 1'b1; tick(); start = 1'b0;
    for (int n = 1; n <= 10; n++) begin
      set_ch(0, (n == 3) ? -32768 : 5);
      tick();
    end
    check_val("i_valid", 32'(res_valid), 1);
`ifdef PEAK_SCAN_ABS_EN
    check_val("i_peak", 32'(res_peak), 32767);
`else
    check_val("i_peak", 32'(res_peak), 5);
`endif
    abort = 1'b1; tick(); abort = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
